ofs_fim_pcie_ss_rx_seg_serializer: RTL

OFS_FIM_PCIE_SS_RX_SEG_SERIALIZER -- requirements
Module: ofs_fim_pcie_ss_rx_seg_serializer

---
 rtl/ofs_fim_pcie_ss_shims_pkg.sv | 54 +++++
 rtl/pcie_ss_axis_if.sv | 19 +
 rtl/ofs_fim_pcie_ss_rx_seg_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types for the PCIe SS RX shims: per-segment tuser layout, serializer
// FSM state and the fragment-selection helper.
package ofs_fim_pcie_ss_shims_pkg;

  localparam int TUSER_HDR_W = 16;
  localparam int MAX_SEG     = 4;

  typedef struct packed {
    logic                   hvalid;
    logic                   last_segment;
    logic [TUSER_HDR_W-1:0] hdr;
  } t_tuser_seg;

  localparam int TUSER_SEG_W = $bits(t_tuser_seg);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } t_ser_state;

  // Next fragment: lowest pending occupied segment, growing upward through
  // contiguous occupied segments; ends on last_segment or before a new header.
  function automatic logic [MAX_SEG-1:0] func_frag_mask(
    input logic [MAX_SEG-1:0] pending,
    input logic [MAX_SEG-1:0] occupied,
    input logic [MAX_SEG-1:0] hvalid,
    input logic [MAX_SEG-1:0] last
  );
    logic [MAX_SEG-1:0] mask;
    logic               started;
    logic               done;
    mask    = '0;
    started = 1'b0;
    done    = 1'b0;
    for (int s = 0; s < MAX_SEG; s++) begin
      if (!done) begin
        if (!started) begin
          if (pending[s] && occupied[s]) begin
            started = 1'b1;
            mask[s] = 1'b1;
            done    = last[s];
          end
        end else if (pending[s] && occupied[s] && !hvalid[s]) begin
          mask[s] = 1'b1;
          done    = last[s];
        end else begin
          done = 1'b1;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/pcie_ss_axis_if.sv
// Segmented AXI-stream bundle used between the PCIe SS RX shims.
// Handshake: a beat transfers on a clk edge where tvalid && tready; a source
// holds tvalid and its payload stable until that edge.
interface pcie_ss_axis_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 2 * ofs_fim_pcie_ss_shims_pkg::TUSER_SEG_W
);

  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0] tuser_vendor;

  modport source (output tvalid, tlast, tdata, tkeep, tuser_vendor, input tready);
  modport sink   (input tvalid, tlast, tdata, tkeep, tuser_vendor, output tready);

endinterface

// File: rtl/ofs_fim_pcie_ss_rx_seg_serializer.sv
// Splits segmented RX beats so each output beat carries one packet fragment.
// Optional split counter: define OFS_FIM_PCIE_SS_RX_SERIALIZER_STATS_EN.
module ofs_fim_pcie_ss_rx_seg_serializer
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter int NUM_OF_SEG  = 2,
  parameter int TDATA_WIDTH = 512
) (
  input  logic           clk,
  input  logic           rst_n,
  pcie_ss_axis_if.sink   stream_in,
  pcie_ss_axis_if.source stream_out,
  output logic [31:0]    stat_split_cnt,
  output t_ser_state     state_dbg
);

  localparam int SEG_DATA_W = TDATA_WIDTH / NUM_OF_SEG;
  localparam int SEG_KEEP_W = SEG_DATA_W / 8;
  localparam int KEEP_W     = TDATA_WIDTH / 8;

  t_ser_state state;
  t_ser_state state_nxt;

  logic [TDATA_WIDTH-1:0]      hold_data;
  logic [KEEP_W-1:0]           hold_keep;
  t_tuser_seg [NUM_OF_SEG-1:0] hold_user;
  logic                        hold_last;
  logic [NUM_OF_SEG-1:0]       pending;

  t_tuser_seg [NUM_OF_SEG-1:0] in_user;
  t_tuser_seg [NUM_OF_SEG-1:0] out_user;
  logic [TDATA_WIDTH-1:0]      out_data;
  logic [KEEP_W-1:0]           out_keep;
  logic [NUM_OF_SEG-1:0]       in_occ;
  logic [NUM_OF_SEG-1:0]       hold_occ;
  logic [NUM_OF_SEG-1:0]       hold_hv;
  logic [NUM_OF_SEG-1:0]       hold_ls;
  logic [NUM_OF_SEG-1:0]       frag;
  logic [MAX_SEG-1:0]          frag_w;
  logic [MAX_SEG-1:0]          rem_w;

  logic in_accept;
  logic out_accept;
  logic last_frag;
  logic in_ready;
  logic out_valid;

  assign in_user = stream_in.tuser_vendor;

  for (genvar s = 0; s < NUM_OF_SEG; s++) begin : g_seg
    assign in_occ[s]   = (|stream_in.tkeep[s*SEG_KEEP_W +: SEG_KEEP_W]) || in_user[s].hvalid;
    assign hold_occ[s] = (|hold_keep[s*SEG_KEEP_W +: SEG_KEEP_W]) || hold_user[s].hvalid;
    assign hold_hv[s]  = hold_user[s].hvalid;
    assign hold_ls[s]  = hold_user[s].last_segment;

    // Fragment segments keep their lane; everything else is blanked.
    assign out_data[s*SEG_DATA_W +: SEG_DATA_W] =
      frag[s] ? hold_data[s*SEG_DATA_W +: SEG_DATA_W] : '0;
    assign out_keep[s*SEG_KEEP_W +: SEG_KEEP_W] =
      frag[s] ? hold_keep[s*SEG_KEEP_W +: SEG_KEEP_W] : '0;
    assign out_user[s] = frag[s] ? hold_user[s] : '0;
  end

  assign frag_w = func_frag_mask(MAX_SEG'(pending), MAX_SEG'(hold_occ),
                                 MAX_SEG'(hold_hv), MAX_SEG'(hold_ls));
  assign frag      = frag_w[NUM_OF_SEG-1:0];
  assign rem_w     = MAX_SEG'(pending) & ~frag_w;
  assign last_frag = (rem_w == '0);

  assign in_accept  = stream_in.tvalid && in_ready;
  assign out_accept = out_valid && stream_out.tready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next state; a beat with no occupied segment never leaves EMPTY.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_accept && (|in_occ)) state_nxt = ST_HOLD;
      ST_HOLD:  if (out_accept && last_frag)
                  state_nxt = (in_accept && (|in_occ)) ? ST_HOLD : ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (state == ST_HOLD);
    in_ready  = rst_n && ((state == ST_EMPTY) || (last_frag && stream_out.tready));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          pending <= '0;
    else if (in_accept)  pending <= in_occ;
    else if (out_accept) pending <= pending & ~frag;
  end

  always_ff @(posedge clk) begin
    if (in_accept) begin
      hold_data <= stream_in.tdata;
      hold_keep <= stream_in.tkeep;
      hold_user <= in_user;
      hold_last <= stream_in.tlast;
    end
  end

  assign stream_in.tready         = in_ready;
  assign stream_out.tvalid        = out_valid;
  assign stream_out.tdata         = out_data;
  assign stream_out.tkeep         = out_keep;
  assign stream_out.tuser_vendor  = out_user;
  assign stream_out.tlast         = (NUM_OF_SEG == 1) ? hold_last : (|(frag_w & MAX_SEG'(hold_ls)));
  assign state_dbg                = state;

`ifdef OFS_FIM_PCIE_SS_RX_SERIALIZER_STATS_EN
  // first_frag marks that the fragment on the output is the first of its beat.
  logic first_frag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_frag     <= 1'b0;
      stat_split_cnt <= '0;
    end else begin
      if (out_accept && !first_frag) stat_split_cnt <= stat_split_cnt + 32'd1;
      if (in_accept)       first_frag <= 1'b1;
      else if (out_accept) first_frag <= 1'b0;
    end
  end
`else
  assign stat_split_cnt = '0;
`endif

endmodule
